// File: rtl/uart_tx_arbiter.sv
// Arbitrates N_REQ byte requesters onto one UART transmitter.
// Round-robin with optional per-requester lock for multi-byte packets; launch is watchdog-timed.
module uart_tx_arbiter #(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned TIMEOUT = 65535
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [8*N_REQ-1:0] req_data,
    input  logic [N_REQ-1:0]   req_lock,
    output logic [N_REQ-1:0]   req_ready,
    output logic [N_REQ-1:0]   req_done,
    output logic [N_REQ-1:0]   grant,
    output logic               tx_start,
    output logic [7:0]         tx_data,
    input  logic               tx_busy,
    input  logic               tx_clear_req,
    output logic               err_timeout
);

    localparam int unsigned IdxW = $clog2(N_REQ);
    localparam int unsigned CntW = 16;

    typedef enum logic [1:0] {StIdle, StLaunch, StActive} state_e;

    state_e              state_q, state_d;
    logic [IdxW-1:0]     ptr_q, ptr_d;
    logic                lock_vld_q, lock_vld_d;
    logic [IdxW-1:0]     lock_idx_q, lock_idx_d;
    logic [IdxW-1:0]     owner_q, owner_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic                tx_start_q, tx_start_d;
    logic [7:0]          tx_data_q, tx_data_d;
    logic [N_REQ-1:0]    grant_q, grant_d;
    logic [N_REQ-1:0]    done_q, done_d;
    logic                err_q, err_d;

    logic                rr_found;
    logic [IdxW-1:0]     rr_idx;
    logic [IdxW-1:0]     cand;
    logic                lock_hit;
    logic [IdxW-1:0]     win_idx;
    logic                accept;

    always_comb begin
        rr_found = 1'b0;
        rr_idx   = '0;
        cand     = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            cand = IdxW'((32'(ptr_q) + i) % N_REQ);
            if (!rr_found && req_valid[cand]) begin
                rr_found = 1'b1;
                rr_idx   = cand;
            end
        end
    end

    assign lock_hit = lock_vld_q && req_valid[lock_idx_q];
    assign win_idx  = lock_hit ? lock_idx_q : rr_idx;
    // No accept in the req_done cycle: completion and the next accept never overlap.
    assign accept   = (state_q == StIdle) && (|req_valid) && (done_q == '0);

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        lock_vld_d = lock_vld_q;
        lock_idx_d = lock_idx_q;
        owner_d    = owner_q;
        cnt_d      = cnt_q;
        tx_start_d = tx_start_q;
        tx_data_d  = tx_data_q;
        grant_d    = grant_q;
        done_d     = '0;
        err_d      = err_q;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d    = StLaunch;
                    tx_data_d  = req_data[{win_idx, 3'b000} +: 8];
                    grant_d    = N_REQ'(1) << win_idx;
                    owner_d    = win_idx;
                    tx_start_d = 1'b1;
                    cnt_d      = '0;
                    if (!lock_hit) begin
                        ptr_d = (win_idx == IdxW'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
                    end
                end
            end
            StLaunch: begin
                if (tx_busy) begin
                    state_d    = StActive;
                    tx_start_d = 1'b0;
                end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
                    state_d    = StIdle;
                    tx_start_d = 1'b0;
                    grant_d    = '0;
                    lock_vld_d = 1'b0;
                    err_d      = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StActive: begin
                if (tx_clear_req) begin
                    state_d    = StIdle;
                    done_d     = grant_q;
                    grant_d    = '0;
                    lock_vld_d = req_lock[owner_q];
                    lock_idx_d = owner_q;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            ptr_q      <= '0;
            lock_vld_q <= 1'b0;
            lock_idx_q <= '0;
            owner_q    <= '0;
            cnt_q      <= '0;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
            grant_q    <= '0;
            done_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            lock_vld_q <= lock_vld_d;
            lock_idx_q <= lock_idx_d;
            owner_q    <= owner_d;
            cnt_q      <= cnt_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
            grant_q    <= grant_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    // Zero-latency handshake: ready is combinational, masked while reset is held.
    assign req_ready   = (accept && rst_n) ? (N_REQ'(1) << win_idx) : '0;
    assign req_done    = done_q;
    assign grant       = grant_q;
    assign tx_start    = tx_start_q;
    assign tx_data     = tx_data_q;
    assign err_timeout = err_q;

endmodule
